// File: rtl/pulse_indicator.sv
// pulse_indicator: turns single-cycle event strobes into fixed-length LED
// blinks, each followed by a fixed gap. Events that arrive during a blink or
// gap are counted in a saturating pending counter and replayed back-to-back.
//
// Build option: define PULSE_INDICATOR_ACTIVE_LOW_EN to drive led_out
// active-low (0 = lit, reset value 1) for common-anode LEDs. Without it,
// led_out is active-high with reset value 0.
module pulse_indicator #(
  parameter int ON_CYCLES  = 4096,
  parameter int OFF_CYCLES = 4096,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pulse_in,
  input  logic              overflow_clr,
  output logic              led_out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // One timer serves both phases, so it is sized for the longer of the two.
  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]     ON_LAST   = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0]     OFF_LAST  = TW'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [TW-1:0]     TIMER_ONE = TW'(1);

`ifdef PULSE_INDICATOR_ACTIVE_LOW_EN
  localparam logic LED_LIT  = 1'b0;
  localparam logic LED_DARK = 1'b1;
`else
  localparam logic LED_LIT  = 1'b1;
  localparam logic LED_DARK = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [PEND_W-1:0]   pend_q,  pend_d;
  logic                ovf_q,   ovf_d;
  logic                led_q,   led_d;
  logic                busy_q,  busy_d;

  logic                inc;
  logic                dec;
  logic                drop;

  // Next-state, timer, pending counter and overflow flag.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    inc     = 1'b0;
    dec     = 1'b0;
    drop    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pulse_in) begin
          state_d = ST_ON;
          timer_d = '0;
        end
      end
      ST_ON: begin
        inc = pulse_in;
        if (timer_q == ON_LAST) begin
          state_d = ST_OFF;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      ST_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (pend_q != '0) begin
            // Replay a queued event; a new strobe in the same cycle queues.
            state_d = ST_ON;
            dec     = 1'b1;
            inc     = pulse_in;
          end else if (pulse_in) begin
            // Nothing queued: the strobe is served directly, no idle gap.
            state_d = ST_ON;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
          inc     = pulse_in;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase

    // Simultaneous replay and new event cancel; otherwise saturate.
    if (inc && dec) begin
      pend_d = pend_q;
    end else if (dec) begin
      pend_d = pend_q - PEND_ONE;
    end else if (inc) begin
      if (pend_q == PEND_MAX) begin
        drop = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end

    // A drop on the same edge as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (overflow_clr) begin
      ovf_d = 1'b0;
    end

    led_d  = (state_d == ST_ON) ? LED_LIT : LED_DARK;
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      led_q   <= LED_DARK;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  assign led_out  = led_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_indicator.sv
// Testbench for pulse_indicator (ON_CYCLES=4, OFF_CYCLES=2, PEND_W=2).
// A time-based model (blink start time + event count) is compared against
// the DUT every cycle; directed scenarios add literal expectations.
// Build with PULSE_INDICATOR_ACTIVE_LOW_EN to exercise the inverted LED.
module tb_pulse_indicator;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 2;
  localparam int PW     = 2;
  localparam int PMAX   = (1 << PW) - 1;

`ifdef PULSE_INDICATOR_ACTIVE_LOW_EN
  localparam bit LED_INV = 1'b1;
`else
  localparam bit LED_INV = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          pulse_in = 1'b0;
  logic          overflow_clr = 1'b0;
  logic          led_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  pulse_indicator #(
    .ON_CYCLES (ON_C),
    .OFF_CYCLES(OFF_C),
    .PEND_W    (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .overflow_clr(overflow_clr),
    .led_out     (led_out),
    .busy        (busy),
    .pending     (pending),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // A blink "service" is described only by the edge at which it started:
  // lit while fewer than ON_C edges have passed, finished after ON_C+OFF_C.
  int edge_cnt = 0;
  bit m_valid  = 1'b0;
  bit m_active = 1'b0;
  int m_start  = 0;
  int m_pend   = 0;
  bit m_ovf    = 1'b0;

  always @(posedge clk) begin
    bit set_ovf;
    edge_cnt = edge_cnt + 1;
    set_ovf  = 1'b0;
    if (reset) begin
      m_active = 1'b0;
      m_pend   = 0;
      m_ovf    = 1'b0;
      m_valid  = 1'b1;
    end else begin
      if (!m_active) begin
        if (pulse_in) begin
          m_active = 1'b1;
          m_start  = edge_cnt;
        end
      end else if (edge_cnt - m_start == ON_C + OFF_C) begin
        if (m_pend > 0) begin
          m_start = edge_cnt;
          m_pend  = m_pend - 1 + (pulse_in ? 1 : 0);
        end else if (pulse_in) begin
          m_start = edge_cnt;
        end else begin
          m_active = 1'b0;
        end
      end else if (pulse_in) begin
        if (m_pend == PMAX) set_ovf = 1'b1;
        else m_pend = m_pend + 1;
      end
      if (set_ovf) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin
    bit exp_led;
    if (m_valid) begin
      exp_led = (m_active && (edge_cnt - m_start) < ON_C) ^ LED_INV;
      checks = checks + 4;
      if (led_out !== exp_led) begin
        errors = errors + 1;
        $display("FAIL model_led edge=%0d got=%b exp=%b", edge_cnt, led_out, exp_led);
      end
      if (busy !== m_active) begin
        errors = errors + 1;
        $display("FAIL model_busy edge=%0d got=%b exp=%b", edge_cnt, busy, m_active);
      end
      if (pending !== PW'(m_pend)) begin
        errors = errors + 1;
        $display("FAIL model_pending edge=%0d got=%0d exp=%0d", edge_cnt, pending, m_pend);
      end
      if (overflow !== m_ovf) begin
        errors = errors + 1;
        $display("FAIL model_overflow edge=%0d got=%b exp=%b", edge_cnt, overflow, m_ovf);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  int base = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then number scenario edges from the reset edge (edge 0).
  task automatic start_scn(input string name);
    reset = 1'b1;
    step();
    reset = 1'b0;
    base = edge_cnt;
    $display("scenario %s: reset at edge %0d", name, edge_cnt);
  endtask

  // Make the given inputs be sampled at scenario edge k.
  task automatic drive_at(input int k, input bit p, input bit c, input bit r);
    while (edge_cnt < base + k - 1) step();
    pulse_in     = p;
    overflow_clr = c;
    reset        = r;
    step();
    pulse_in     = 1'b0;
    overflow_clr = 1'b0;
    reset        = 1'b0;
    $display("drive edge %0d: pulse=%b clr=%b reset=%b", k, p, c, r);
  endtask

  // Compare DUT outputs just after scenario edge k against literals.
  task automatic chk_at(input int k, input string name, input bit led_lit,
                        input bit b, input int p, input bit o);
    bit exp_led;
    while (edge_cnt < base + k) step();
    exp_led = led_lit ^ LED_INV;
    checks  = checks + 1;
    if (led_out !== exp_led || busy !== b || pending !== PW'(p) || overflow !== o) begin
      errors = errors + 1;
      $display("FAIL %s edge=%0d got led=%b busy=%b pend=%0d ovf=%b exp led=%b busy=%b pend=%0d ovf=%b",
               name, k, led_out, busy, pending, overflow, exp_led, b, p, o);
    end else begin
      $display("check %s edge=%0d led=%b busy=%b pend=%0d ovf=%b ok",
               name, k, led_out, busy, pending, overflow);
    end
  endtask

  initial begin
    // Scenario 1: single pulse.
    start_scn("single");
    chk_at(0,  "s1_reset",    1'b0, 1'b0, 0, 1'b0);
    drive_at(10, 1'b1, 1'b0, 1'b0);
    chk_at(10, "s1_on_first", 1'b1, 1'b1, 0, 1'b0);
    chk_at(13, "s1_on_last",  1'b1, 1'b1, 0, 1'b0);
    chk_at(14, "s1_off_first",1'b0, 1'b1, 0, 1'b0);
    chk_at(15, "s1_off_last", 1'b0, 1'b1, 0, 1'b0);
    chk_at(16, "s1_idle",     1'b0, 1'b0, 0, 1'b0);

    // Scenario 2: three queued pulses.
    start_scn("three");
    drive_at(10, 1'b1, 1'b0, 1'b0);
    drive_at(11, 1'b1, 1'b0, 1'b0);
    chk_at(11, "s2_pend1",    1'b1, 1'b1, 1, 1'b0);
    drive_at(12, 1'b1, 1'b0, 1'b0);
    chk_at(12, "s2_pend2",    1'b1, 1'b1, 2, 1'b0);
    chk_at(15, "s2_gap1",     1'b0, 1'b1, 2, 1'b0);
    chk_at(16, "s2_blink2",   1'b1, 1'b1, 1, 1'b0);
    chk_at(22, "s2_blink3",   1'b1, 1'b1, 0, 1'b0);
    chk_at(27, "s2_gap3",     1'b0, 1'b1, 0, 1'b0);
    chk_at(28, "s2_idle",     1'b0, 1'b0, 0, 1'b0);

    // Scenario 3: saturation; the drop coincides with a clear (set wins).
    start_scn("saturate");
    for (int k = 10; k <= 13; k++) drive_at(k, 1'b1, 1'b0, 1'b0);
    chk_at(13, "s3_pend_full",1'b1, 1'b1, 3, 1'b0);
    drive_at(14, 1'b1, 1'b1, 1'b0);
    chk_at(14, "s3_drop",     1'b0, 1'b1, 3, 1'b1);
    chk_at(28, "s3_blink4",   1'b1, 1'b1, 0, 1'b1);
    chk_at(34, "s3_idle",     1'b0, 1'b0, 0, 1'b1);
    chk_at(39, "s3_sticky",   1'b0, 1'b0, 0, 1'b1);
    drive_at(40, 1'b0, 1'b1, 1'b0);
    chk_at(40, "s3_clr",      1'b0, 1'b0, 0, 1'b0);

    // Scenario 4: new pulse in the final gap cycle restarts without idling.
    start_scn("replay");
    drive_at(10, 1'b1, 1'b0, 1'b0);
    chk_at(15, "s4_gap_last", 1'b0, 1'b1, 0, 1'b0);
    drive_at(16, 1'b1, 1'b0, 1'b0);
    chk_at(16, "s4_restart",  1'b1, 1'b1, 0, 1'b0);
    chk_at(19, "s4_on_last",  1'b1, 1'b1, 0, 1'b0);
    chk_at(21, "s4_gap_end",  1'b0, 1'b1, 0, 1'b0);
    chk_at(22, "s4_idle",     1'b0, 1'b0, 0, 1'b0);

    // Scenario 5: reset mid-blink with events queued; pulse at reset ignored.
    start_scn("midreset");
    drive_at(9,  1'b1, 1'b0, 1'b0);
    drive_at(10, 1'b1, 1'b0, 1'b0);
    drive_at(11, 1'b1, 1'b0, 1'b0);
    chk_at(11, "s5_pend2",    1'b1, 1'b1, 2, 1'b0);
    drive_at(12, 1'b1, 1'b0, 1'b1);
    chk_at(12, "s5_reset",    1'b0, 1'b0, 0, 1'b0);
    drive_at(20, 1'b1, 1'b0, 1'b0);
    chk_at(23, "s5_fresh_on", 1'b1, 1'b1, 0, 1'b0);
    chk_at(24, "s5_fresh_off",1'b0, 1'b1, 0, 1'b0);
    chk_at(26, "s5_idle",     1'b0, 1'b0, 0, 1'b0);

    // Extra: a burst with a replay-cycle pulse while events are queued.
    start_scn("burst");
    drive_at(5, 1'b1, 1'b0, 1'b0);
    drive_at(7, 1'b1, 1'b0, 1'b0);
    drive_at(11, 1'b1, 1'b0, 1'b0);
    chk_at(11, "s6_replay_inc", 1'b1, 1'b1, 1, 1'b0);
    drive_at(14, 1'b1, 1'b0, 1'b0);
    chk_at(30, "s6_drain",    1'b0, 1'b0, 0, 1'b0);

    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
